fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Fetch/decode/execute sequencer for the paper processor.
//   Holds the program counter (PC) and instruction register (IR), requests instructions from memory,
//   and resolves jumps and zero-branches.
//   Produces a one-cycle register-write strobe that downstream dff-based state elements consume as their load condition.
// PARAMETERS
//   ADDR_W    8      PC / instruction-memory address width
//   INSTR_W   16     instruction width; opcode is ir[INSTR_W-1 -: OPC_W]
//   OPC_W     4      opcode width
//   HALT_OPC  4'hF   opcode that stops the sequencer
//   JMP_OPC   4'hE   unconditional jump, target = ir[ADDR_W-1:0]
//   BRZ_OPC   4'hD   jump to ir[ADDR_W-1:0] if zero_flag=1
// PORTS
//   clk        in   1        clock; all state changes on posedge clk
//   r          in   1        reset, synchronous, active-high
//   run        in   1        start execution from IDLE
//   mem_req    out  1        instruction read request, address = pc
//   mem_ready  in   1        memory has valid mem_rdata this cycle
//   mem_rdata  in   INSTR_W  instruction word
//   zero_flag  in   1        ALU zero flag, sampled in DECODE
//   exec_done  in   1        datapath finished current instruction
//   pc         out  ADDR_W   program counter (registered)
//   ir         out  INSTR_W  instruction register (registered)
//   reg_we     out  1        register-file write strobe
//   halted     out  1        sequencer stopped on HALT_OPC
//   state      out  3        current state encoding, for debug
// BEHAVIOUR
//   Reset
//   - r=1 at posedge has priority over all else.
//   - Next state: pc=0, ir=0, state=IDLE; mem_req=0, reg_we=0, halted=0.
//   - Reset mid-operation (any state, incl. mid-fetch) abandons the access and the pending write.
//   Outputs and encoding
//   - mem_req, reg_we and halted are decoded from the state register only; no combinational input-to-output path.
//   - Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5; 6 and 7 go to IDLE next cycle.
//   State transitions
//   - IDLE: run=1 -> FETCH; otherwise hold.
//   - FETCH: mem_req=1. On mem_ready=1: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W, 0xFF->0x00), -> DECODE.
//     Otherwise hold with pc and ir unchanged. Minimum fetch = 1 cycle.
//   - DECODE (1 cycle), decode on opc = ir[INSTR_W-1 -: OPC_W]:
//     - HALT_OPC -> HALT.
//     - JMP_OPC: pc<=ir[ADDR_W-1:0] -> FETCH.
//     - BRZ_OPC: if zero_flag, pc<=ir[ADDR_W-1:0]; -> FETCH either way.
//     - Any other opcode -> EXEC.
//   - EXEC: wait; exec_done=1 -> WB. exec_done in the same cycle as entry counts.
//   - WB: reg_we=1 for exactly this one cycle -> FETCH.
//   - HALT: halted=1; pc and ir frozen; run, mem_ready and exec_done ignored. Exit only via r.
//   Ignored inputs
//   - mem_ready outside FETCH is ignored.
//   - exec_done outside EXEC is ignored.
//   - run outside IDLE is ignored.
//   Latency
//   - ALU instruction with immediate ready/done: FETCH, DECODE, EXEC, WB = 4 cycles.
//   - Jump or branch: FETCH, DECODE = 2 cycles.
// TESTING
//   1. r=1 for 2 cycles, then r=0, run=0 for 5 cycles -> pc=0, ir=0, state=0, mem_req=reg_we=halted=0 throughout.
//   2. run=1; mem_rdata=16'h1234 with mem_ready after 3 wait cycles; exec_done at first EXEC cycle
//      -> ir=16'h1234, pc=1; reg_we high exactly 1 cycle; back in FETCH 4 cycles after mem_ready.
//   3. Fetch 16'hE0FE (JMP) -> pc=8'hFE after DECODE, next mem_req with pc=8'hFE.
//      Then fetch ALU op at 8'hFF -> pc wraps to 8'h00.
//   4. Fetch 16'hD040 (BRZ):
//      - zero_flag=1 -> pc=8'h40, reg_we never asserted.
//      - repeat with zero_flag=0 -> pc = fetch address + 1.
//   5. Fetch 16'hF000 -> halted=1 from the cycle after DECODE.
//      Pulse run, mem_ready, exec_done -> pc, ir, state unchanged. Then r=1 -> IDLE, halted=0.
//   6. Assert r=1 in FETCH (mem_ready=0), in EXEC and in WB -> next cycle state=IDLE, pc=0, ir=0, reg_we=0.
//      Verify a mem_ready in the same cycle as r does not load ir.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: owns PC and IR, fetches from memory, resolves jump/zero-branch.
// ALU op takes 4 cycles and jump/branch 2, given immediate ready/done; stalls in FETCH/EXEC until mem_ready/exec_done.
module fetch_sequencer #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 16,
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF,
  parameter logic [OPC_W-1:0] JMP_OPC  = 4'hE,
  parameter logic [OPC_W-1:0] BRZ_OPC  = 4'hD
) (
  input  logic               clk,
  input  logic               r,
  input  logic               run,
  output logic               mem_req,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               zero_flag,
  input  logic               exec_done,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic               reg_we,
  output logic               halted,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [OPC_W-1:0]   opc;

  assign opc = ir_q[INSTR_W-1 -: OPC_W];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc == HALT_OPC) begin
          state_d = S_HALT;
        end else if (opc == JMP_OPC) begin
          pc_d    = ir_q[ADDR_W-1:0];
          state_d = S_FETCH;
        end else if (opc == BRZ_OPC) begin
          if (zero_flag) pc_d = ir_q[ADDR_W-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes come from the state register alone so no input can glitch them.
  assign mem_req = (state_q == S_FETCH);
  assign reg_we  = (state_q == S_WB);
  assign halted  = (state_q == S_HALT);
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign state   = state_q;

endmodule
